// File: rtl/eth_fc_pkg.sv
// Shared types and constants for the 802.3x pause-frame flow-control logic.
//   fc_state_t     : scheduler state encoding
//   PAUSE_MCAST_DA : reserved MAC-control multicast destination address
//   XON_QUANTA     : quanta value that resumes the link partner
package eth_fc_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ_XOFF = 2'd1,
        S_PAUSED   = 2'd2,
        S_REQ_XON  = 2'd3
    } fc_state_t;

    localparam logic [47:0] PAUSE_MCAST_DA = 48'h0180C2000001;
    localparam logic [15:0] XON_QUANTA     = 16'h0000;

endpackage

// File: rtl/pause_flow_scheduler.sv
// Watermark-driven pause-frame scheduler between the bridge RX FIFO and the
// MAC pause transmit interface. Sends XOFF when the FIFO fills past HI_WM,
// refreshes it before the advertised quanta run out, and sends XON once the
// FIFO drains to LO_WM. Every MAC request uses a req/ack handshake.
//
// Ports:
//   tx_clk            in   clock
//   rstn              in   synchronous active-low reset
//   fc_en             in   flow-control enable
//   fifo_level        in   RX FIFO occupancy in words
//   tx_pause_ack      in   MAC accepted the pending request
//   tx_pause_req      out  pause request, held until acked
//   tx_pause_val      out  quanta of the pending request, 0 when idle
//   tx_pause_dst_addr out  MAC-control multicast while pending, else 0
//   xoff_active       out  link partner is currently paused
//   pause_frame_cnt   out  acked pause frames, saturating
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no pause in effect, watching for level >= HI_WM
// S_REQ_XOFF | XOFF (initial or refresh) offered to the MAC, awaiting ack
// S_PAUSED   | partner paused, refresh timer counting down
// S_REQ_XON  | XON offered to the MAC, awaiting ack
module pause_flow_scheduler
    import eth_fc_pkg::*;
#(
    parameter int unsigned LVL_W        = 12,
    parameter int unsigned HI_WM        = 1536,
    parameter int unsigned LO_WM        = 512,
    parameter logic [15:0] PAUSE_QUANTA = 16'h5a0f,
    parameter int unsigned REFRESH_CYC  = 20000
) (
    input  logic             tx_clk,
    input  logic             rstn,
    input  logic             fc_en,
    input  logic [LVL_W-1:0] fifo_level,
    input  logic             tx_pause_ack,
    output logic             tx_pause_req,
    output logic [15:0]      tx_pause_val,
    output logic [47:0]      tx_pause_dst_addr,
    output logic             xoff_active,
    output logic [15:0]      pause_frame_cnt
);

    localparam logic [LVL_W-1:0] HI_LVL       = LVL_W'(HI_WM);
    localparam logic [LVL_W-1:0] LO_LVL       = LVL_W'(LO_WM);
    localparam logic [23:0]      REFRESH_LOAD = 24'(REFRESH_CYC - 1);

    fc_state_t   state;
    fc_state_t   state_next;
    logic [23:0] timer;
    logic [23:0] timer_next;
    logic        req_next;
    logic [15:0] val_next;
    logic [47:0] dst_next;
    logic        xoff_next;
    logic [15:0] cnt_next;
    logic        ack_seen;
    logic        xon_cond;

    // The registered req mirrors the request states, so gating with it makes
    // an ack arriving while nothing is offered a no-op.
    assign ack_seen = tx_pause_ack && tx_pause_req;
    assign xon_cond = !fc_en || (fifo_level <= LO_LVL);

    always_ff @(posedge tx_clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (fc_en && (fifo_level >= HI_LVL)) state_next = S_REQ_XOFF;
            end
            S_REQ_XOFF: begin
                if (ack_seen) state_next = S_PAUSED;
            end
            S_PAUSED: begin
                // XON takes priority over a refresh falling due in the same cycle.
                if (xon_cond)           state_next = S_REQ_XON;
                else if (timer == '0)   state_next = S_REQ_XOFF;
            end
            S_REQ_XON: begin
                if (ack_seen) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state and registered, so req, val
    // and dst_addr always change together on the same edge.
    always_comb begin
        req_next   = 1'b0;
        val_next   = 16'h0000;
        dst_next   = 48'h0;
        xoff_next  = xoff_active;
        cnt_next   = pause_frame_cnt;
        timer_next = timer;

        unique case (state_next)
            S_REQ_XOFF: begin
                req_next = 1'b1;
                val_next = PAUSE_QUANTA;
                dst_next = PAUSE_MCAST_DA;
            end
            S_REQ_XON: begin
                req_next = 1'b1;
                val_next = XON_QUANTA;
                dst_next = PAUSE_MCAST_DA;
            end
            default: ;
        endcase

        if (ack_seen && (state == S_REQ_XOFF || state == S_REQ_XON)) begin
            if (pause_frame_cnt != 16'hFFFF) cnt_next = pause_frame_cnt + 16'd1;
            xoff_next = (state == S_REQ_XOFF);
        end

        if (state == S_REQ_XOFF && ack_seen) begin
            timer_next = REFRESH_LOAD;
        end else if (state == S_PAUSED && timer != '0) begin
            timer_next = timer - 24'd1;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (!rstn) begin
            tx_pause_req      <= 1'b0;
            tx_pause_val      <= 16'h0000;
            tx_pause_dst_addr <= 48'h0;
            xoff_active       <= 1'b0;
            pause_frame_cnt   <= 16'h0000;
            timer             <= 24'h0;
        end else begin
            tx_pause_req      <= req_next;
            tx_pause_val      <= val_next;
            tx_pause_dst_addr <= dst_next;
            xoff_active       <= xoff_next;
            pause_frame_cnt   <= cnt_next;
            timer             <= timer_next;
        end
    end

endmodule

// File: tb/tb_pause_flow_scheduler.sv
module tb_pause_flow_scheduler;

    localparam int          LVL_W   = 12;
    localparam int          HI      = 1536;
    localparam int          LO      = 512;
    localparam logic [15:0] QUANTA  = 16'h5a0f;
    localparam int          REFRESH = 100;
    localparam logic [47:0] DA      = 48'h0180C2000001;

    logic             tx_clk = 1'b0;
    logic             rstn = 1'b0;
    logic             fc_en = 1'b0;
    logic [LVL_W-1:0] fifo_level = '0;
    logic             tx_pause_ack = 1'b0;
    logic             tx_pause_req;
    logic [15:0]      tx_pause_val;
    logic [47:0]      tx_pause_dst_addr;
    logic             xoff_active;
    logic [15:0]      pause_frame_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model: which request (if any) is outstanding, whether the
    // partner is paused, how many paused cycles remain before a refresh is
    // due, and how many frames the MAC has accepted.
    int m_kind   = 0;   // 0 none, 1 XOFF outstanding, 2 XON outstanding
    bit m_paused = 0;
    int m_left   = 0;
    int m_cnt    = 0;

    pause_flow_scheduler #(
        .LVL_W(LVL_W), .HI_WM(HI), .LO_WM(LO),
        .PAUSE_QUANTA(QUANTA), .REFRESH_CYC(REFRESH)
    ) dut (
        .tx_clk(tx_clk), .rstn(rstn), .fc_en(fc_en), .fifo_level(fifo_level),
        .tx_pause_ack(tx_pause_ack), .tx_pause_req(tx_pause_req),
        .tx_pause_val(tx_pause_val), .tx_pause_dst_addr(tx_pause_dst_addr),
        .xoff_active(xoff_active), .pause_frame_cnt(pause_frame_cnt)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic model_update(input logic r, input logic f, input int lvl, input logic a);
        if (!r) begin
            m_kind = 0; m_paused = 0; m_left = 0; m_cnt = 0;
        end else if (m_kind == 1) begin
            if (a) begin
                m_kind = 0; m_paused = 1; m_left = REFRESH;
                if (m_cnt < 65535) m_cnt++;
            end
        end else if (m_kind == 2) begin
            if (a) begin
                m_kind = 0; m_paused = 0;
                if (m_cnt < 65535) m_cnt++;
            end
        end else if (m_paused) begin
            if (!f || lvl <= LO)   m_kind = 2;
            else if (m_left == 1)  m_kind = 1;
            else                   m_left--;
        end else if (f && lvl >= HI) begin
            m_kind = 1;
        end
    endtask

    task automatic step(input logic r, input logic f, input int lvl, input logic a);
        rstn = r; fc_en = f; fifo_level = LVL_W'(lvl); tx_pause_ack = a;
        @(posedge tx_clk);
        model_update(r, f, lvl, a);
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0);
        step(0, 1, 2000, 1);
        checks++;
        if ({tx_pause_req, tx_pause_val, tx_pause_dst_addr, xoff_active, pause_frame_cnt} !== 82'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%0b val=%h dst=%h xoff=%0b cnt=%0d, want all zero",
                     tx_pause_req, tx_pause_val, tx_pause_dst_addr, xoff_active, pause_frame_cnt);
        end
        step(1, 1, 1000, 0);
        checks++;
        if (tx_pause_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_mid_level: got req=%0b, want 0", tx_pause_req);
        end
    endtask

    task automatic test_xoff();
        step(1, 1, 1536, 0);
        checks++;
        if (tx_pause_req !== 1'b1 || tx_pause_val !== QUANTA || tx_pause_dst_addr !== DA) begin
            errors++;
            $display("FAIL xoff_request: got req=%0b val=%h dst=%h, want 1 %h %h",
                     tx_pause_req, tx_pause_val, tx_pause_dst_addr, QUANTA, DA);
        end
        step(1, 1, 1536, 1);
        checks++;
        if (tx_pause_req !== 1'b0 || tx_pause_val !== 16'h0 || tx_pause_dst_addr !== 48'h0 ||
            xoff_active !== 1'b1 || pause_frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL xoff_ack: got req=%0b val=%h dst=%h xoff=%0b cnt=%0d, want 0 0 0 1 1",
                     tx_pause_req, tx_pause_val, tx_pause_dst_addr, xoff_active, pause_frame_cnt);
        end
    endtask

    task automatic test_refresh();
        int n = 0;
        while (tx_pause_req !== 1'b1 && n < 3 * REFRESH) begin
            step(1, 1, 1000, 0);
            n++;
        end
        checks++;
        if (n != REFRESH || tx_pause_val !== QUANTA) begin
            errors++;
            $display("FAIL refresh_period: got %0d cycles val=%h, want %0d cycles val=%h", n, tx_pause_val, REFRESH, QUANTA);
        end
        step(1, 1, 1000, 1);
        checks++;
        if (pause_frame_cnt !== 16'd2 || xoff_active !== 1'b1) begin
            errors++;
            $display("FAIL refresh_ack: got cnt=%0d xoff=%0b, want 2 1", pause_frame_cnt, xoff_active);
        end
    endtask

    task automatic test_xon();
        step(1, 1, 512, 0);
        checks++;
        if (tx_pause_req !== 1'b1 || tx_pause_val !== 16'h0 || tx_pause_dst_addr !== DA) begin
            errors++;
            $display("FAIL xon_request: got req=%0b val=%h dst=%h, want 1 0 %h", tx_pause_req, tx_pause_val, tx_pause_dst_addr, DA);
        end
        step(1, 1, 512, 1);
        checks++;
        if (xoff_active !== 1'b0 || tx_pause_req !== 1'b0 || pause_frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL xon_ack: got xoff=%0b req=%0b cnt=%0d, want 0 0 3", xoff_active, tx_pause_req, pause_frame_cnt);
        end
        for (int i = 0; i < 10; i++) step(1, 1, 1000, 0);
        checks++;
        if (tx_pause_req !== 1'b0 || xoff_active !== 1'b0) begin
            errors++;
            $display("FAIL hysteresis: got req=%0b xoff=%0b, want 0 0", tx_pause_req, xoff_active);
        end
    endtask

    task automatic test_simultaneous();
        step(1, 1, 2000, 0);
        step(1, 1, 2000, 1);
        // Stray ack with nothing offered must change nothing.
        step(1, 1, 1000, 1);
        checks++;
        if (tx_pause_req !== 1'b0 || xoff_active !== 1'b1 || pause_frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL stray_ack: got req=%0b xoff=%0b cnt=%0d, want 0 1 4", tx_pause_req, xoff_active, pause_frame_cnt);
        end
        for (int i = 0; i < REFRESH - 2; i++) step(1, 1, 1000, 0);
        step(1, 1, 500, 0);
        checks++;
        if (tx_pause_req !== 1'b1 || tx_pause_val !== 16'h0) begin
            errors++;
            $display("FAIL expiry_vs_xon: got req=%0b val=%h, want 1 0000", tx_pause_req, tx_pause_val);
        end
        step(1, 1, 500, 1);
        step(1, 1, 500, 0);
    endtask

    task automatic test_fc_disable_hold();
        step(1, 1, 1600, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1600, 0);
        checks++;
        if (tx_pause_req !== 1'b1 || tx_pause_val !== QUANTA) begin
            errors++;
            $display("FAIL xoff_held: got req=%0b val=%h, want 1 %h", tx_pause_req, tx_pause_val, QUANTA);
        end
        step(1, 0, 1600, 1);
        checks++;
        if (tx_pause_req !== 1'b0 || xoff_active !== 1'b1) begin
            errors++;
            $display("FAIL disabled_ack: got req=%0b xoff=%0b, want 0 1", tx_pause_req, xoff_active);
        end
        step(1, 0, 1600, 0);
        checks++;
        if (tx_pause_req !== 1'b1 || tx_pause_val !== 16'h0) begin
            errors++;
            $display("FAIL disabled_xon: got req=%0b val=%h, want 1 0000", tx_pause_req, tx_pause_val);
        end
    endtask

    task automatic test_reset_mid_request();
        step(0, 1, 1600, 0);
        checks++;
        if ({tx_pause_req, tx_pause_val, tx_pause_dst_addr, xoff_active, pause_frame_cnt} !== 82'h0) begin
            errors++;
            $display("FAIL reset_mid_req: got req=%0b val=%h dst=%h xoff=%0b cnt=%0d, want all zero",
                     tx_pause_req, tx_pause_val, tx_pause_dst_addr, xoff_active, pause_frame_cnt);
        end
    endtask

    task automatic test_saturation();
        step(1, 1, 1600, 0);
        force dut.pause_frame_cnt = 16'hFFFF;
        #1;
        release dut.pause_frame_cnt;
        m_cnt = 65535;
        step(1, 1, 1600, 1);
        checks++;
        if (pause_frame_cnt !== 16'hFFFF || xoff_active !== 1'b1) begin
            errors++;
            $display("FAIL cnt_saturate: got cnt=%h xoff=%0b, want ffff 1", pause_frame_cnt, xoff_active);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_random();
        int lvl_mode = 0;
        int seg = 0;
        logic r, f, a;
        int lvl;
        logic [81:0] exp_v, got_v;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (seg == 0) begin
                lvl_mode = $urandom_range(0, 3);
                seg = $urandom_range(20, 250);
            end
            seg--;
            case (lvl_mode)
                0:       lvl = $urandom_range(0, LO);
                1:       lvl = $urandom_range(LO + 1, HI - 1);
                2:       lvl = $urandom_range(HI, 4095);
                default: lvl = $urandom_range(0, 4095);
            endcase
            r = ($urandom_range(0, 599) != 0);
            f = ($urandom_range(0, 19) != 0);
            a = ($urandom_range(0, 2) == 0);
            step(r, f, lvl, a);
            exp_v = {m_kind != 0,
                     (m_kind == 1) ? QUANTA : 16'h0,
                     (m_kind != 0) ? DA : 48'h0,
                     m_paused,
                     16'(m_cnt)};
            got_v = {tx_pause_req, tx_pause_val, tx_pause_dst_addr, xoff_active, pause_frame_cnt};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h, want %h (req|val|dst|xoff|cnt)", cyc, got_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_xoff();
        test_refresh();
        test_xon();
        test_simultaneous();
        test_fc_disable_hold();
        test_reset_mid_request();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
